hilbert_mac_sequencer: RTL

//  Control FSM for the time-multiplexed Hilbert FIR datapath. On each input sample it

---
 rtl/hilbert_mac_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hilbert_mac_sequencer.sv
// Control sequencer for a time-multiplexed antisymmetric (Hilbert) FIR: shift the delay line,
// walk the nonzero tap pairs through one shared MAC, wait for the MAC pipeline, strobe the output.
module hilbert_mac_sequencer #(
  parameter int unsigned TAPS    = 31,
  parameter int unsigned MAC_LAT = 2,
  localparam int unsigned C      = (TAPS - 1) / 2,
  localparam int unsigned P      = (C + 1) / 2,
  localparam int unsigned AW     = $clog2(TAPS),
  localparam int unsigned CW     = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          RST_n,
  input  logic          sample_valid,
  output logic          shift_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [AW-1:0] tap_a,
  output logic [AW-1:0] tap_b,
  output logic [CW-1:0] coef_addr,
  output logic          out_en,
  output logic          ready,
  output logic          overrun
);

  localparam int unsigned DW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          shift_en_q, shift_en_d;
  logic          acc_en_q, acc_en_d;
  logic [AW-1:0] tap_a_q, tap_a_d;
  logic [AW-1:0] tap_b_q, tap_b_d;
  logic [CW-1:0] coef_addr_q, coef_addr_d;
  logic          out_en_q, out_en_d;
  logic          overrun_q, overrun_d;
  logic          busy;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Next state, counters, and the next-cycle output image (decoded from next state).
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_d     = drain_q;
    shift_en_d  = 1'b0;
    acc_en_d    = 1'b0;
    tap_a_d     = '0;
    tap_b_d     = '0;
    coef_addr_d = '0;
    out_en_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sample_valid) state_d = SHIFT;
      end
      SHIFT: begin
        state_d = MAC;
        k_d     = '0;
        drain_d = '0;
      end
      MAC: begin
        if (k_q == CW'(P - 1)) begin
          state_d = (MAC_LAT == 0) ? DONE : DRAIN;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(MAC_LAT - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = sample_valid ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    shift_en_d = (state_d == SHIFT);
    out_en_d   = (state_d == DONE);
    if (state_d == MAC) begin
      acc_en_d    = 1'b1;
      tap_a_d     = AW'(k_d) << 1;
      tap_b_d     = AW'(TAPS - 1) - tap_a_d;
      coef_addr_d = k_d;
    end
  end

  assign busy      = (state_q == SHIFT) || (state_q == MAC) || (state_q == DRAIN);
  assign overrun_d = sample_valid && busy;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      shift_en_q  <= 1'b0;
      acc_en_q    <= 1'b0;
      tap_a_q     <= '0;
      tap_b_q     <= '0;
      coef_addr_q <= '0;
      out_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_en_q  <= shift_en_d;
      acc_en_q    <= acc_en_d;
      tap_a_q     <= tap_a_d;
      tap_b_q     <= tap_b_d;
      coef_addr_q <= coef_addr_d;
      out_en_q    <= out_en_d;
      overrun_q   <= overrun_d;
    end
  end

  assign shift_en  = shift_en_q;
  assign acc_clr   = shift_en_q;
  assign acc_en    = acc_en_q;
  assign tap_a     = tap_a_q;
  assign tap_b     = tap_b_q;
  assign coef_addr = coef_addr_q;
  assign out_en    = out_en_q;
  assign overrun   = overrun_q;
  assign ready     = (state_q == IDLE) || (state_q == DONE);

endmodule
